// File: rtl/d0_wr_arbiter.sv
// Round-robin arbiter for the single write port of the D0 register.
// Optional hold-grant locking is compiled in with the D0_ARB_LOCK_EN macro.
module d0_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic                  d0_stall,
`ifdef D0_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    req_lock,
`endif
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  d0_we,
  output logic [DW-1:0]         d0_wdata,
  output logic                  busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_next;
  logic [PW-1:0]      rr_ptr_reg;
  logic [PW-1:0]      rr_ptr_next;
  logic [PW-1:0]      sel_idx;
  logic [PW-1:0]      cand;
  logic               sel_valid;
  logic               lock_hold;
  logic [DW-1:0]      wdata_next;
  logic               busy_next;
  int                 cand_int;

  // The requester granted last cycle sits out this arbitration.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign elig[gi] = req[gi] & ~gnt[gi];
    end
  endgenerate

`ifdef D0_ARB_LOCK_EN
  localparam int LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
  logic [LCW-1:0] lock_cnt_reg;

  // A locked requester keeps the port until it has had LOCK_MAX grants in a row.
  assign lock_hold = (|(gnt & req & req_lock)) && (lock_cnt_reg < LCW'(LOCK_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_reg <= '0;
    end else if (lock_hold && !d0_stall) begin
      lock_cnt_reg <= lock_cnt_reg + 1'b1;
    end else begin
      lock_cnt_reg <= '0;
    end
  end
`else
  assign lock_hold = 1'b0;
`endif

  // First eligible index scanning upward from rr_ptr with wrap.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_int = int'(rr_ptr_reg) + k;
      if (cand_int >= NUM_REQ) begin
        cand_int = cand_int - NUM_REQ;
      end
      cand = PW'(cand_int);
      if (!sel_valid && elig[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_next    = '0;
    rr_ptr_next = rr_ptr_reg;
    if (!d0_stall) begin
      if (lock_hold) begin
        gnt_next = gnt;
      end else if (sel_valid) begin
        gnt_next[sel_idx] = 1'b1;
        rr_ptr_next = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
      end
    end
  end

  always_comb begin
    wdata_next = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_next[k]) begin
        wdata_next = wdata_next | req_data[k*DW +: DW];
      end
    end
  end

  assign busy_next = |(req & ~gnt_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      d0_we      <= 1'b0;
      d0_wdata   <= '0;
      busy       <= 1'b0;
      rr_ptr_reg <= '0;
    end else begin
      gnt        <= gnt_next;
      d0_we      <= |gnt_next;
      busy       <= busy_next;
      rr_ptr_reg <= rr_ptr_next;
      if (|gnt_next) begin
        d0_wdata <= wdata_next;
      end
    end
  end

endmodule

// File: tb/tb_d0_wr_arbiter.sv
// Randomised and directed bench for d0_wr_arbiter against a behavioural model.
// Exercises the lock path when built with D0_ARB_LOCK_EN.
module tb_d0_wr_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 4;
`ifdef D0_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            d0_stall = 1'b0;
  logic [N-1:0]    gnt;
  logic            d0_we;
  logic [DW-1:0]   d0_wdata;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Model state: last granted index (-1 = none), pointer, lock run length.
  int            m_gnt = -1;
  int            m_ptr = 0;
  int            m_lock = 0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_busy = 1'b0;

  d0_wr_arbiter #(.NUM_REQ(N), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .d0_stall (d0_stall),
`ifdef D0_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .gnt      (gnt),
    .d0_we    (d0_we),
    .d0_wdata (d0_wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] e_gnt;
    e_gnt = '0;
    if (m_gnt >= 0) e_gnt[m_gnt] = 1'b1;
    check({tag, "/gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, "/we"}, 32'(d0_we), 32'(m_gnt >= 0));
    check({tag, "/wdata"}, 32'(d0_wdata), 32'(m_wdata));
    check({tag, "/busy"}, 32'(busy), 32'(m_busy));
  endtask

  task automatic model_reset();
    m_gnt   = -1;
    m_ptr   = 0;
    m_lock  = 0;
    m_wdata = '0;
    m_busy  = 1'b0;
  endtask

  // Predict the next cycle from current inputs, clock once, then compare.
  task automatic step(input string tag);
    int nxt, best_d, d;
    bit locked;
    nxt    = -1;
    locked = 1'b0;
    if (!d0_stall) begin
      if (LOCK_EN && m_gnt >= 0 && req[m_gnt] && req_lock[m_gnt] && m_lock < LOCK_MAX - 1) begin
        nxt    = m_gnt;
        locked = 1'b1;
      end else begin
        best_d = N;
        for (int j = 0; j < N; j++) begin
          if (req[j] && j != m_gnt) begin
            d = (j - m_ptr + N) % N;
            if (d < best_d) begin
              best_d = d;
              nxt    = j;
            end
          end
        end
      end
    end
    m_busy = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (req[j] && j != nxt) m_busy = 1'b1;
    end
    if (nxt >= 0) begin
      m_wdata = req_data[nxt*DW +: DW];
      if (!locked) m_ptr = (nxt + 1) % N;
    end
    m_lock = locked ? m_lock + 1 : 0;
    m_gnt  = nxt;
    @(posedge clk);
    #1;
    $display("%s req=%b lock=%b stall=%b gnt=%b we=%b wdata=%h busy=%b",
             tag, req, req_lock, d0_stall, gnt, d0_we, d0_wdata, busy);
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    repeat (5) step("idle");

    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    step("single");
    req = 4'b0000;
    step("single_drop");

    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
    repeat (8) step("rr_all");

    req = 4'b0101;
    d0_stall = 1'b1;
    repeat (3) step("stall");
    d0_stall = 1'b0;
    repeat (3) step("post_stall");

    req = 4'b0010;
    step("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    step("after_rst");

`ifdef D0_ARB_LOCK_EN
    req = 4'b0011;
    req_lock = 4'b0001;
    repeat (7) step("lock");
    req_lock = '0;
`endif

    repeat (400) begin
      req      = N'($urandom);
      req_data = $urandom;
      d0_stall = ($urandom_range(0, 4) == 0);
      req_lock = N'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
